// File: rtl/multi_channel_sample_mixer.sv
// Sample-rate mixer: on each tick, sums attenuated channel samples one channel per cycle,
// saturates the sum to the sample width and writes it to a downstream FIFO.
module multi_channel_sample_mixer #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 20,
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int SAMPLE_RATE  = 48_000
) (
    input  logic                                 system_clock,
    input  logic                                 system_reset,
    input  logic                                 enable,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] ch_data,
    input  logic [NUM_CHANNELS-1:0]              ch_valid,
    output logic [NUM_CHANNELS-1:0]              ch_ready,
    input  logic [NUM_CHANNELS*4-1:0]            ch_volume,
    output logic [SAMPLE_WIDTH-1:0]              fifo_din,
    output logic                                 fifo_wr_en,
    input  logic                                 fifo_full,
    output logic                                 clip_pulse,
    output logic [15:0]                          underrun_count,
    output logic [15:0]                          overrun_count
);

    localparam int PERIOD = SYS_CLK_FREQ / SAMPLE_RATE;
    localparam int CntW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IdxW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int AccW   = SAMPLE_WIDTH + 3;

    localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHANNELS - 1);
    localparam logic signed [AccW-1:0] MaxAcc = {4'b0000, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [AccW-1:0] MinAcc = {4'b1111, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StSat, StWrite} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic [SAMPLE_WIDTH-1:0] dout_q, dout_d;
    logic                    clip_q, clip_d;
    logic [15:0]             underrun_q, underrun_d;
    logic [15:0]             overrun_q, overrun_d;
    logic                    tick;

    logic signed [SAMPLE_WIDTH-1:0] ch_sample [NUM_CHANNELS];
    logic [3:0]                     ch_vol    [NUM_CHANNELS];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
        assign ch_sample[i] = ch_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        assign ch_vol[i]    = ch_volume[i*4 +: 4];
    end

    logic signed [SAMPLE_WIDTH-1:0] cur_shifted;
    logic signed [SAMPLE_WIDTH-1:0] cur_term;
    logic signed [AccW-1:0]         cur_ext;
    logic [SAMPLE_WIDTH-1:0]        clamped;
    logic                           sat_hit;

    // Volume 15 is a hard mute; a plain shift would leave -1 for negative samples.
    always_comb begin
        cur_shifted = ch_sample[idx_q] >>> ch_vol[idx_q];
        cur_term    = (ch_vol[idx_q] == 4'hF) ? '0 : cur_shifted;
        cur_ext     = {{3{cur_term[SAMPLE_WIDTH-1]}}, cur_term};
    end

    always_comb begin
        clamped = acc_q[SAMPLE_WIDTH-1:0];
        sat_hit = 1'b0;
        if (acc_q > MaxAcc) begin
            clamped = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (acc_q < MinAcc) begin
            clamped = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    always_comb begin
        tick = enable && (cnt_q == LastCnt);
        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick) state_d = StAccum;
            StAccum: if (idx_q == LastIdx) state_d = StSat;
            StSat:   state_d = StWrite;
            StWrite: if (!fifo_full) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        ch_ready   = '0;
        fifo_wr_en = 1'b0;
        if (state_q == StAccum) begin
            ch_ready = NUM_CHANNELS'(1) << idx_q;
        end
        if (state_q == StWrite) begin
            fifo_wr_en = !fifo_full;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        acc_d      = acc_q;
        dout_d     = dout_q;
        clip_d     = 1'b0;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    acc_d = '0;
                    idx_d = '0;
                end
            end
            StAccum: begin
                if (ch_valid[idx_q]) begin
                    acc_d = acc_q + cur_ext;
                end else if (underrun_q != 16'hFFFF) begin
                    underrun_d = underrun_q + 16'd1;
                end
                idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
            end
            StSat: begin
                dout_d = clamped;
                clip_d = sat_hit;
            end
            default: ;
        endcase
        if (tick && (state_q != StIdle) && (overrun_q != 16'hFFFF)) begin
            overrun_d = overrun_q + 16'd1;
        end
    end

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            dout_q     <= '0;
            clip_q     <= 1'b0;
            underrun_q <= '0;
            overrun_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            dout_q     <= dout_d;
            clip_q     <= clip_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign fifo_din       = dout_q;
    assign clip_pulse     = clip_q;
    assign underrun_count = underrun_q;
    assign overrun_count  = overrun_q;

endmodule

// File: tb/tb_multi_channel_sample_mixer.sv
// Self-checking bench for multi_channel_sample_mixer: randomized channel data against an
// arithmetic mix model, plus directed clip, underrun, back-pressure, reset and enable cases.
module tb_multi_channel_sample_mixer;

    localparam int N      = 2;
    localparam int SW     = 20;
    localparam int CLK_HZ = 50_000_000;
    localparam int RATE   = 48_000;
    localparam int P      = CLK_HZ / RATE;
    localparam int MAXS   = (1 << (SW - 1)) - 1;
    localparam int MINS   = -(1 << (SW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [N*SW-1:0] ch_data = '0;
    logic [N-1:0]  ch_valid = '0;
    logic [N-1:0]  ch_ready;
    logic [N*4-1:0] ch_volume = '0;
    logic [SW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          fifo_full = 1'b0;
    logic          clip_pulse;
    logic [15:0]   underrun_count;
    logic [15:0]   overrun_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_under = 0;
    int exp_over = 0;

    int wr_cyc[$];
    int wr_val[$];
    int clip_cyc[$];
    logic [N-1:0] rdy_log[$];

    int cd[N];
    bit cv[N];
    int cvol[N];

    multi_channel_sample_mixer #(
        .NUM_CHANNELS(N),
        .SAMPLE_WIDTH(SW),
        .SYS_CLK_FREQ(CLK_HZ),
        .SAMPLE_RATE (RATE)
    ) dut (
        .system_clock  (clk),
        .system_reset  (rst),
        .enable        (enable),
        .ch_data       (ch_data),
        .ch_valid      (ch_valid),
        .ch_ready      (ch_ready),
        .ch_volume     (ch_volume),
        .fifo_din      (fifo_din),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_full     (fifo_full),
        .clip_pulse    (clip_pulse),
        .underrun_count(underrun_count),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: writes, clip pulses and ready strobes, tagged with the cycle number.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_val.push_back(int'($signed(fifo_din)));
        end
        if (clip_pulse) clip_cyc.push_back(cyc);
        if (ch_ready != '0) rdy_log.push_back(ch_ready);
    end

    task automatic cyc_wait(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_cyc.delete();
        wr_val.delete();
        clip_cyc.delete();
        rdy_log.delete();
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            ch_data[i*SW +: SW]  = cd[i][SW-1:0];
            ch_valid[i]          = cv[i];
            ch_volume[i*4 +: 4]  = cvol[i][3:0];
        end
    endtask

    function automatic int rand_sample();
        logic [SW-1:0] r;
        r = SW'($urandom);
        return int'($signed(r));
    endfunction

    // Reference mix: sum of valid, attenuated samples, then clamp to the output range.
    function automatic int model_mix(output bit clip, output int under);
        int sum = 0;
        under = 0;
        for (int i = 0; i < N; i++) begin
            if (!cv[i]) under++;
            else if (cvol[i] != 15) sum += cd[i] >>> cvol[i];
        end
        clip = 0;
        if (sum > MAXS) begin
            sum = MAXS;
            clip = 1;
        end else if (sum < MINS) begin
            sum = MINS;
            clip = 1;
        end
        return sum;
    endfunction

    // Raises enable from a zeroed tick counter and waits (bounded) for the resulting write.
    task automatic run_sample(output bit got, output int wc, output int wv, output int start);
        clear_logs();
        apply();
        cyc_wait(1);
        enable = 1'b1;
        start = cyc;
        got = 0;
        wc = -1;
        wv = 0;
        for (int k = 0; k < P + N + 20 && !got; k++) begin
            cyc_wait(1);
            if (wr_cyc.size() > 0) got = 1;
        end
        enable = 1'b0;
        if (got) begin
            wc = wr_cyc[0];
            wv = wr_val[0];
        end
        cyc_wait(N + 6);
    endtask

    task automatic test_reset();
        cyc_wait(3);
        checks++; if (fifo_din !== '0) begin errors++; $display("FAIL reset_din got %0d expected 0", fifo_din); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b expected 0", fifo_wr_en); end
        checks++; if (ch_ready !== '0) begin errors++; $display("FAIL reset_ready got %0b expected 0", ch_ready); end
        checks++; if (clip_pulse !== 1'b0) begin errors++; $display("FAIL reset_clip got %0b expected 0", clip_pulse); end
        checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_under got %0d expected 0", underrun_count); end
        checks++; if (overrun_count !== 16'd0) begin errors++; $display("FAIL reset_over got %0d expected 0", overrun_count); end
        rst = 1'b0;
        cyc_wait(2);
    endtask

    task automatic test_clip();
        bit got, eclip;
        int wc, wv, st, exp, eu;
        cd[0] = 300000; cd[1] = 300000;
        cv[0] = 1; cv[1] = 1;
        cvol[0] = 0; cvol[1] = 0;
        exp = model_mix(eclip, eu);
        run_sample(got, wc, wv, st);
        checks++; if (!got) begin errors++; $display("FAIL clip_write got none expected one write"); end
        checks++; if (wv !== exp) begin errors++; $display("FAIL clip_value got %0d expected %0d", wv, exp); end
        // Tick lands in the PERIOD-th enabled cycle; the write follows N+2 cycles later.
        checks++; if (wc !== st + P + N + 1) begin errors++; $display("FAIL clip_latency got %0d expected %0d", wc - st, P + N + 1); end
        checks++; if (clip_cyc.size() !== int'(eclip)) begin errors++; $display("FAIL clip_pulse_cycles got %0d expected %0d", clip_cyc.size(), eclip); end
        checks++; if (wr_cyc.size() !== 1) begin errors++; $display("FAIL clip_write_count got %0d expected 1", wr_cyc.size()); end
    endtask

    task automatic test_attenuate();
        bit got, eclip;
        int wc, wv, st, exp, eu;
        logic [N-1:0] r0, r1;
        cd[0] = -500000; cd[1] = 100000;
        cv[0] = 1; cv[1] = 1;
        cvol[0] = 1; cvol[1] = 0;
        exp = model_mix(eclip, eu);
        run_sample(got, wc, wv, st);
        r0 = (rdy_log.size() > 0) ? rdy_log[0] : '0;
        r1 = (rdy_log.size() > 1) ? rdy_log[1] : '0;
        checks++; if (wv !== exp) begin errors++; $display("FAIL atten_value got %0d expected %0d", wv, exp); end
        checks++; if (clip_cyc.size() !== 0) begin errors++; $display("FAIL atten_clip got %0d expected 0", clip_cyc.size()); end
        checks++; if (rdy_log.size() !== N) begin errors++; $display("FAIL atten_ready_len got %0d expected %0d", rdy_log.size(), N); end
        checks++; if (r0 !== 2'b01) begin errors++; $display("FAIL atten_ready0 got %b expected 01", r0); end
        checks++; if (r1 !== 2'b10) begin errors++; $display("FAIL atten_ready1 got %b expected 10", r1); end
    endtask

    task automatic test_underrun_mute();
        bit got, eclip;
        int wc, wv, st, exp, eu;
        cd[0] = -300000; cd[1] = 12345;
        cv[0] = 1; cv[1] = 0;
        cvol[0] = 0; cvol[1] = 0;
        exp = model_mix(eclip, eu);
        exp_under += eu;
        run_sample(got, wc, wv, st);
        checks++; if (wv !== exp) begin errors++; $display("FAIL under_value got %0d expected %0d", wv, exp); end
        checks++; if (underrun_count !== 16'(exp_under)) begin errors++; $display("FAIL under_count got %0d expected %0d", underrun_count, exp_under); end
        cv[1] = 1; cd[1] = 0; cvol[0] = 15;
        exp = model_mix(eclip, eu);
        run_sample(got, wc, wv, st);
        checks++; if (wv !== exp) begin errors++; $display("FAIL mute_value got %0d expected %0d", wv, exp); end
        checks++; if (rdy_log.size() < 1 || rdy_log[0] !== 2'b01) begin errors++; $display("FAIL mute_consumed got %0d strobes expected ch0 strobe", rdy_log.size()); end
        checks++; if (underrun_count !== 16'(exp_under)) begin errors++; $display("FAIL mute_under got %0d expected %0d", underrun_count, exp_under); end
    endtask

    task automatic test_fifo_full();
        bit eclip, stable;
        int exp, eu, rel;
        logic [SW-1:0] held;
        for (int i = 0; i < N; i++) begin
            cd[i] = rand_sample(); cv[i] = 1; cvol[i] = $urandom_range(0, 3);
        end
        exp = model_mix(eclip, eu);
        clear_logs();
        apply();
        fifo_full = 1'b1;
        cyc_wait(1);
        enable = 1'b1;
        cyc_wait(P + N + 1);
        held = fifo_din;
        stable = 1;
        for (int k = 0; k < 3 * P + 1; k++) begin
            cyc_wait(1);
            if (fifo_wr_en !== 1'b0 || fifo_din !== held) stable = 0;
        end
        exp_over += 3;
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL full_hold got %0b expected 1", stable); end
        checks++; if (wr_cyc.size() !== 0) begin errors++; $display("FAIL full_no_write got %0d expected 0", wr_cyc.size()); end
        checks++; if (overrun_count !== 16'(exp_over)) begin errors++; $display("FAIL full_overrun got %0d expected %0d", overrun_count, exp_over); end
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
        rel = cyc;
        cyc_wait(N + 4);
        enable = 1'b0;
        cyc_wait(2);
        checks++; if (wr_cyc.size() !== 1) begin errors++; $display("FAIL full_release_count got %0d expected 1", wr_cyc.size()); end
        checks++; if (wr_cyc.size() > 0 && wr_val[0] !== exp) begin errors++; $display("FAIL full_release_value got %0d expected %0d", wr_val[0], exp); end
        checks++; if (wr_cyc.size() > 0 && wr_cyc[0] !== rel) begin errors++; $display("FAIL full_release_cycle got %0d expected %0d", wr_cyc[0], rel); end
    endtask

    task automatic test_async_reset();
        bit got, eclip;
        int wc, wv, st, exp, eu;
        for (int i = 0; i < N; i++) begin
            cd[i] = rand_sample(); cv[i] = 1; cvol[i] = $urandom_range(0, 3);
        end
        clear_logs();
        apply();
        cyc_wait(1);
        enable = 1'b1;
        cyc_wait(P);
        checks++; if (ch_ready !== 2'b01) begin errors++; $display("FAIL arst_in_accum got %b expected 01", ch_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (fifo_din !== '0) begin errors++; $display("FAIL arst_din got %0d expected 0", fifo_din); end
        checks++; if (ch_ready !== '0 || fifo_wr_en !== 1'b0 || clip_pulse !== 1'b0) begin errors++; $display("FAIL arst_outputs got ready=%b wr=%b clip=%b expected all 0", ch_ready, fifo_wr_en, clip_pulse); end
        checks++; if (underrun_count !== 16'd0 || overrun_count !== 16'd0) begin errors++; $display("FAIL arst_counters got %0d/%0d expected 0/0", underrun_count, overrun_count); end
        enable = 1'b0;
        exp_under = 0;
        exp_over = 0;
        cyc_wait(2);
        rst = 1'b0;
        cyc_wait(N + 6);
        checks++; if (wr_cyc.size() !== 0) begin errors++; $display("FAIL arst_no_write got %0d expected 0", wr_cyc.size()); end
        exp = model_mix(eclip, eu);
        run_sample(got, wc, wv, st);
        checks++; if (wv !== exp || wc !== st + P + N + 1) begin errors++; $display("FAIL arst_recover got %0d at +%0d expected %0d at +%0d", wv, wc - st, exp, P + N + 1); end
    endtask

    task automatic test_enable_low();
        bit got, eclip;
        int wc, wv, st, exp, eu;
        clear_logs();
        cyc_wait(5000);
        checks++; if (wr_cyc.size() !== 0) begin errors++; $display("FAIL en_low_writes got %0d expected 0", wr_cyc.size()); end
        checks++; if (overrun_count !== 16'(exp_over)) begin errors++; $display("FAIL en_low_overrun got %0d expected %0d", overrun_count, exp_over); end
        for (int i = 0; i < N; i++) begin
            cd[i] = rand_sample(); cv[i] = 1; cvol[i] = $urandom_range(0, 2);
        end
        exp = model_mix(eclip, eu);
        run_sample(got, wc, wv, st);
        checks++; if (wc !== st + P + N + 1) begin errors++; $display("FAIL en_first_write got +%0d expected +%0d", wc - st, P + N + 1); end
        checks++; if (wv !== exp) begin errors++; $display("FAIL en_value got %0d expected %0d", wv, exp); end
    endtask

    task automatic test_random();
        bit got, eclip;
        int wc, wv, st, exp, eu;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                cd[i]   = rand_sample();
                cv[i]   = ($urandom_range(0, 3) != 0);
                cvol[i] = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 3));
            end
            exp = model_mix(eclip, eu);
            exp_under += eu;
            run_sample(got, wc, wv, st);
            checks++; if (!got || wv !== exp) begin errors++; $display("FAIL rand%0d_value got %0d expected %0d", r, wv, exp); end
            checks++; if (wc !== st + P + N + 1) begin errors++; $display("FAIL rand%0d_latency got +%0d expected +%0d", r, wc - st, P + N + 1); end
            checks++; if (clip_cyc.size() !== int'(eclip)) begin errors++; $display("FAIL rand%0d_clip got %0d expected %0d", r, clip_cyc.size(), eclip); end
            checks++; if (underrun_count !== 16'(exp_under)) begin errors++; $display("FAIL rand%0d_under got %0d expected %0d", r, underrun_count, exp_under); end
            checks++; if (wr_cyc.size() !== 1) begin errors++; $display("FAIL rand%0d_writes got %0d expected 1", r, wr_cyc.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_clip();
        test_attenuate();
        test_underrun_mute();
        test_fifo_full();
        test_async_reset();
        test_enable_low();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
